// File: rtl/comet_ii_decode_sequencer.sv
// ----------------------------------------------------------------------------
// comet_ii_decode_sequencer
//
// Clocked fetch/execute sequencer for the COMET II datapath. Fetches one or
// two instruction words from memory, latches them into an internal IR,
// traps illegal opcodes and out-of-range register indices, and emits
// single-cycle control strobes in the EXEC commit cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               leave IDLE/TRAP and begin fetching
//   halt                sampled at EXEC commit: go to IDLE instead of IFET1
//   mem_rdata/valid     fetched word and its valid qualifier
//   exec_stall          datapath not ready, holds EXEC
//   FR                  flags {OF,SF,ZF} for conditional jumps
//   fetch_req           high in IFET1/IFET2
//   state               IDLE=000 IFET1=010 IFET2=011 EXEC=100 TRAP=111
//   op_code,r_r1,x_r2   latched IR1 fields; adr = latched second word
//   ALU_mode            ALU operation select (1111 = no ALU operation)
//   inc_pr..ret         control strobes to the datapath
//   illegal             high while in TRAP
// ----------------------------------------------------------------------------
module comet_ii_decode_sequencer #(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned GR_NUM  = 8,
    parameter bit          TRAP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_valid,
    input  logic              exec_stall,
    input  logic [2:0]        FR,
    output logic              fetch_req,
    output logic [2:0]        state,
    output logic [7:0]        op_code,
    output logic [3:0]        r_r1,
    output logic [3:0]        x_r2,
    output logic [WORD_W-1:0] adr,
    output logic [3:0]        ALU_mode,
    output logic              inc_pr,
    output logic              r_adr_x,
    output logic              r1_r2,
    output logic              set_GR_al,
    output logic              store,
    output logic              lad,
    output logic              set_FR,
    output logic              shift,
    output logic              compare,
    output logic              jump,
    output logic              dec_SP,
    output logic              push,
    output logic              pop,
    output logic              call,
    output logic              ret,
    output logic              illegal
);

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StIfet1 = 3'b010,
        StIfet2 = 3'b011,
        StExec  = 3'b100,
        StTrap  = 3'b111
    } state_t;

    localparam logic [4:0] GrNum = 5'(GR_NUM);
    localparam logic [3:0] AluNop = 4'b1111;

    function automatic logic f_one_word(input logic [7:0] op);
        case (op)
            8'h00, 8'h14, 8'h24, 8'h25, 8'h26, 8'h27, 8'h34, 8'h35, 8'h36,
            8'h44, 8'h45, 8'h71, 8'h81: f_one_word = 1'b1;
            default:                    f_one_word = 1'b0;
        endcase
    endfunction

    function automatic logic f_two_word(input logic [7:0] op);
        case (op)
            8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31,
            8'h32, 8'h40, 8'h41, 8'h50, 8'h51, 8'h52, 8'h53, 8'h61, 8'h62,
            8'h63, 8'h64, 8'h65, 8'h66, 8'h70, 8'h80: f_two_word = 1'b1;
            default:                                  f_two_word = 1'b0;
        endcase
    endfunction

    // Input is the opcode with bit 2 cleared so register and memory forms
    // share one entry.
    function automatic logic [3:0] f_alu(input logic [7:0] op);
        case (op)
            8'h10:   f_alu = 4'b0111;
            8'h20:   f_alu = 4'b1000;
            8'h21:   f_alu = 4'b1001;
            8'h22:   f_alu = 4'b1010;
            8'h23:   f_alu = 4'b1011;
            8'h30:   f_alu = 4'b1100;
            8'h31:   f_alu = 4'b1101;
            8'h32:   f_alu = 4'b1110;
            8'h40:   f_alu = 4'b0000;
            8'h41:   f_alu = 4'b0001;
            8'h50:   f_alu = 4'b0100;
            8'h51:   f_alu = 4'b0101;
            8'h52:   f_alu = 4'b0010;
            8'h53:   f_alu = 4'b0011;
            default: f_alu = AluNop;
        endcase
    endfunction

    state_t             r_state;
    state_t             w_state_d;
    logic [15:0]        r_ir1;
    logic [WORD_W-1:0]  r_adr;
    logic               r_nop;      // latched invalid word executed as NOP

    logic [15:0]        w_word;
    logic               w_one;
    logic               w_valid;
    logic [7:0]         w_op;
    logic [3:0]         w_alu;
    logic               w_is_alu;
    logic               w_acc1;
    logic               w_acc2;
    logic               w_ofl;
    logic               w_sfl;
    logic               w_zfl;

    // Legality of the word arriving in IFET1; only steers next state.
    assign w_word  = mem_rdata[15:0];
    assign w_one   = f_one_word(w_word[15:8]);
    assign w_valid = (w_one || f_two_word(w_word[15:8]))
                     && ({1'b0, w_word[7:4]} < GrNum)
                     && ({1'b0, w_word[3:0]} < GrNum);

    assign w_acc1 = (r_state == StIfet1) && mem_valid;
    assign w_acc2 = (r_state == StIfet2) && mem_valid;

    // Execution decode works on registered IR only.
    assign w_op     = r_nop ? 8'h00 : r_ir1[15:8];
    assign w_alu    = f_alu(w_op & 8'hFB);
    assign w_is_alu = (w_alu != AluNop);
    assign {w_ofl, w_sfl, w_zfl} = FR;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_ir1   <= '0;
            r_adr   <= '0;
            r_nop   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_acc1) begin
                r_ir1 <= w_word;
                r_nop <= !w_valid;
            end
            if (w_acc2) begin
                r_adr <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        fetch_req = 1'b0;
        inc_pr    = 1'b0;
        r_adr_x   = 1'b0;
        r1_r2     = 1'b0;
        set_GR_al = 1'b0;
        store     = 1'b0;
        lad       = 1'b0;
        set_FR    = 1'b0;
        shift     = 1'b0;
        compare   = 1'b0;
        jump      = 1'b0;
        dec_SP    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        call      = 1'b0;
        ret       = 1'b0;
        illegal   = 1'b0;
        ALU_mode  = w_alu;

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StIfet1;
                end
            end
            StIfet1: begin
                fetch_req = 1'b1;
                if (mem_valid) begin
                    inc_pr = 1'b1;
                    if (!w_valid && TRAP_EN) begin
                        w_state_d = StTrap;
                    end else if (!w_valid || w_one) begin
                        w_state_d = StExec;
                    end else begin
                        w_state_d = StIfet2;
                    end
                end
            end
            StIfet2: begin
                fetch_req = 1'b1;
                if (mem_valid) begin
                    inc_pr    = 1'b1;
                    dec_SP    = (r_ir1[15:8] == 8'h70) || (r_ir1[15:8] == 8'h80);
                    w_state_d = StExec;
                end
            end
            StExec: begin
                if (!exec_stall) begin
                    r1_r2     = w_is_alu && w_op[2];
                    r_adr_x   = f_two_word(w_op);
                    set_GR_al = w_is_alu && (w_alu != 4'b0000) && (w_alu != 4'b0001);
                    store     = (w_op == 8'h11);
                    lad       = (w_op == 8'h12);
                    set_FR    = w_is_alu;
                    shift     = w_is_alu && (w_op[7:4] == 4'h5);
                    compare   = w_is_alu && (w_op[7:4] == 4'h4);
                    push      = (w_op == 8'h70);
                    pop       = (w_op == 8'h71);
                    call      = (w_op == 8'h80);
                    ret       = (w_op == 8'h81);
                    case (w_op)
                        8'h61:   jump = w_sfl;
                        8'h62:   jump = !w_zfl;
                        8'h63:   jump = w_zfl;
                        8'h64:   jump = 1'b1;
                        8'h65:   jump = !w_sfl && !w_zfl;
                        8'h66:   jump = w_ofl;
                        default: jump = 1'b0;
                    endcase
                    w_state_d = halt ? StIdle : StIfet1;
                end
            end
            StTrap: begin
                illegal = 1'b1;
                if (start) begin
                    w_state_d = StIfet1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Reset cycle shows quiescent outputs, even mid-fetch or mid-stall.
        if (rst) begin
            fetch_req = 1'b0;
            inc_pr    = 1'b0;
            r_adr_x   = 1'b0;
            r1_r2     = 1'b0;
            set_GR_al = 1'b0;
            store     = 1'b0;
            lad       = 1'b0;
            set_FR    = 1'b0;
            shift     = 1'b0;
            compare   = 1'b0;
            jump      = 1'b0;
            dec_SP    = 1'b0;
            push      = 1'b0;
            pop       = 1'b0;
            call      = 1'b0;
            ret       = 1'b0;
            illegal   = 1'b0;
            ALU_mode  = AluNop;
        end
    end

    assign state   = r_state;
    assign op_code = r_ir1[15:8];
    assign r_r1    = r_ir1[7:4];
    assign x_r2    = r_ir1[3:0];
    assign adr     = r_adr;

endmodule
